// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder: one shared 4-bit ripple slice processes a nibble per clock, LSB first.
// Optional signed-overflow flag is built when OVERFLOW_DETECT_EN is defined.
module nibble_serial_adder_ctrl #(
    parameter  int WIDTH = 16,
    localparam int NIB   = WIDTH / 4,
    localparam int IDXW  = (NIB > 1) ? $clog2(NIB) : 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [IDXW-1:0]  nibble_idx,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic             carry_reg, cout_reg;
    logic [IDXW-1:0]  idx_reg;
    logic             accept, last_nib;
    logic [3:0]       a_nib, b_nib, slice_sum;
    logic [4:0]       slice_c;

    // Operand nibble mux feeding the shared slice.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int k = 0; k < NIB; k++) begin
            if (idx_reg == IDXW'(k)) begin
                a_nib = a_reg[k*4 +: 4];
                b_nib = b_reg[k*4 +: 4];
            end
        end
    end

    assign slice_c[0] = carry_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign slice_sum[gi]  = a_nib[gi] ^ b_nib[gi] ^ slice_c[gi];
            assign slice_c[gi+1]  = (a_nib[gi] & b_nib[gi]) | (slice_c[gi] & (a_nib[gi] ^ b_nib[gi]));
        end
    endgenerate

    assign last_nib = (idx_reg == IDXW'(NIB - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // DONE behaves like IDLE towards start, giving back-to-back operation.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_nib) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx_reg   <= '0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            sum_reg   <= '0;
            idx_reg   <= '0;
        end else if (state_reg == RUN) begin
            for (int k = 0; k < NIB; k++) begin
                if (idx_reg == IDXW'(k)) begin
                    sum_reg[k*4 +: 4] <= slice_sum;
                end
            end
            carry_reg <= slice_c[4];
            if (last_nib) begin
                cout_reg <= slice_c[4];
                idx_reg  <= '0;
            end else begin
                idx_reg  <= idx_reg + 1'b1;
            end
        end
    end

`ifdef OVERFLOW_DETECT_EN
    logic ovf_reg;

    // Two's-complement overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ovf_reg <= 1'b0;
        end else if (accept) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == RUN && last_nib) begin
            ovf_reg <= slice_c[3] ^ slice_c[4];
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

    assign busy       = (state_reg == RUN);
    assign done       = (state_reg == DONE);
    assign sum        = sum_reg;
    assign cout       = cout_reg;
    assign nibble_idx = idx_reg;

endmodule
